s_p_buffer: RTL and testbench

- Serial-to-parallel front end of the 16-point radix-4 FFT core.
- Accepts one complex sample per cycle and stores a 16-sample frame.
- Emits the four radix-4 stage-1 input groups, each x[k], x[k+4], x[k+8], x[k+12], to the butterfly input mux.
- Raises s_p_flag when the 13th sample of a frame lands; this starts the downstream controller's tick sequence.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/sp_mem16.sv | 28 ++
 rtl/s_p_buffer.sv | 114 +++++++++++
 tb/tb_s_p_buffer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sample type and capture-state encoding for the FFT front end.
package fft_pkg;

    localparam int DW       = 16;
    localparam int N        = 16;
    localparam int FLAG_IDX = 12;
    localparam int CW       = $clog2(N);

    localparam logic [CW-1:0] FLAG_CNT = CW'(FLAG_IDX);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } sp_state_t;

endpackage

// File: rtl/sp_mem16.sv
// 16-entry complex-sample register file: one write port, three stride-4 read ports.
module sp_mem16
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_addr,
    input  cplx_t         wr_data,
    input  logic [1:0]    rd_grp,
    output cplx_t         rd0,
    output cplx_t         rd1,
    output cplx_t         rd2
);

    // Not reset: contents are always rewritten before a group reads them.
    cplx_t mem [N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd0 = mem[{2'b00, rd_grp}];
    assign rd1 = mem[{2'b01, rd_grp}];
    assign rd2 = mem[{2'b10, rd_grp}];

endmodule

// File: rtl/s_p_buffer.sv
// Serial-to-parallel front end: captures 16-sample frames and issues radix-4 stage-1 groups.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_FILL  | collecting indices 0..12, in_valid gaps tolerated
//   ST_DRAIN | indices 13..15, one sample per cycle, a gap drops the frame
module s_p_buffer
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          s_p_flag,
    output logic          out_valid,
    output logic [1:0]    out_grp,
    output logic [DW-1:0] out0_re,
    output logic [DW-1:0] out0_im,
    output logic [DW-1:0] out1_re,
    output logic [DW-1:0] out1_im,
    output logic [DW-1:0] out2_re,
    output logic [DW-1:0] out2_im,
    output logic [DW-1:0] out3_re,
    output logic [DW-1:0] out3_im,
    output logic          frame_err
);

    sp_state_t     state;
    logic [CW-1:0] wr_cnt;
    cplx_t         in_smp;
    cplx_t         rd0;
    cplx_t         rd1;
    cplx_t         rd2;
    logic          grp_issue;

    assign in_smp = '{re: in_re, im: in_im};

    // Indices 12..15 each complete one group; the group index is the low two bits.
    assign grp_issue = in_valid && (wr_cnt >= FLAG_CNT);

    sp_mem16 u_mem (
        .clk     (clk),
        .wr_en   (in_valid),
        .wr_addr (wr_cnt),
        .wr_data (in_smp),
        .rd_grp  (wr_cnt[1:0]),
        .rd0     (rd0),
        .rd1     (rd1),
        .rd2     (rd2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            wr_cnt    <= '0;
            s_p_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_grp   <= 2'd0;
            frame_err <= 1'b0;
            out0_re   <= '0;
            out0_im   <= '0;
            out1_re   <= '0;
            out1_im   <= '0;
            out2_re   <= '0;
            out2_im   <= '0;
            out3_re   <= '0;
            out3_im   <= '0;
        end else begin
            s_p_flag  <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                ST_FILL: begin
                    if (in_valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == FLAG_CNT) begin
                            state    <= ST_DRAIN;
                            s_p_flag <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (in_valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST_CNT) begin
                            state <= ST_FILL;
                        end
                    end else begin
                        frame_err <= 1'b1;
                        wr_cnt    <= '0;
                        state     <= ST_FILL;
                    end
                end
            endcase

            // x[k+12] is the sample arriving now, so it bypasses the memory.
            if (grp_issue) begin
                out_valid <= 1'b1;
                out_grp   <= wr_cnt[1:0];
                out0_re   <= rd0.re;
                out0_im   <= rd0.im;
                out1_re   <= rd1.re;
                out1_im   <= rd1.im;
                out2_re   <= rd2.re;
                out2_im   <= rd2.im;
                out3_re   <= in_re;
                out3_im   <= in_im;
            end
        end
    end

endmodule

// File: tb/tb_s_p_buffer.sv
// Directed vector bench for s_p_buffer: frame capture, gaps, back-to-back, drain drop, async reset.
module tb_s_p_buffer;
    import fft_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          s_p_flag;
    logic          out_valid;
    logic [1:0]    out_grp;
    logic [DW-1:0] out0_re, out0_im, out1_re, out1_im;
    logic [DW-1:0] out2_re, out2_im, out3_re, out3_im;
    logic          frame_err;

    s_p_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .s_p_flag  (s_p_flag),
        .out_valid (out_valid),
        .out_grp   (out_grp),
        .out0_re   (out0_re),
        .out0_im   (out0_im),
        .out1_re   (out1_re),
        .out1_im   (out1_im),
        .out2_re   (out2_re),
        .out2_im   (out2_im),
        .out3_re   (out3_re),
        .out3_im   (out3_im),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             vld;
        logic [15:0]      re;
        logic [15:0]      im;
        logic             flag;
        logic             ov;
        logic [1:0]       grp;
        logic             err;
        logic [3:0][15:0] ore;
        logic [3:0][15:0] oim;
    } vec_t;

    vec_t             vq[$];
    logic [3:0][15:0] hold_re;
    logic [3:0][15:0] hold_im;
    int               total;
    int               bad;
    int               cyc;
    int               flag_cyc[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic vld, input logic [15:0] re, input logic [15:0] im,
                                input logic flag, input logic ov, input logic [1:0] grp,
                                input logic err, input logic [3:0][15:0] ore,
                                input logic [3:0][15:0] oim);
        vec_t v;
        if (ov) begin
            hold_re = ore;
            hold_im = oim;
        end
        v.vld = vld; v.re = re; v.im = im;
        v.flag = flag; v.ov = ov; v.grp = grp; v.err = err;
        v.ore = hold_re; v.oim = hold_im;
        vq.push_back(v);
    endfunction

    function automatic void add_idle(input logic err);
        add(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 2'd0, err, hold_re, hold_im);
    endfunction

    // Expected groups computed straight from the frame formula: x[i] = base+i, or constant.
    function automatic void build_frame(input int base, input bit gaps, input bit maxmin, input int upto);
        logic [15:0]      re, im;
        logic [3:0][15:0] ore, oim;
        for (int i = 0; i <= upto; i++) begin
            if (gaps && i >= 1 && i <= 12)
                for (int g = 0; g <= i % 3; g++) add_idle(1'b0);
            re = maxmin ? 16'h7FFF : 16'(base + i);
            im = maxmin ? 16'h8000 : 16'(-(base + i));
            if (i >= 12) begin
                for (int j = 0; j < 4; j++) begin
                    ore[j] = maxmin ? 16'h7FFF : 16'(base + (i - 12) + 4 * j);
                    oim[j] = maxmin ? 16'h8000 : 16'(-(base + (i - 12) + 4 * j));
                end
                add(1'b1, re, im, (i == 12), 1'b1, 2'(i - 12), 1'b0, ore, oim);
            end else begin
                add(1'b1, re, im, 1'b0, 1'b0, 2'd0, 1'b0, hold_re, hold_im);
            end
        end
    endfunction

    task automatic run(input string tag);
        vec_t v;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            @(negedge clk);
            in_valid = v.vld;
            in_re    = v.re;
            in_im    = v.im;
            @(posedge clk);
            #1;
            cyc++;
            if (s_p_flag) flag_cyc.push_back(cyc);
            chk($sformatf("%s[%0d] flag", tag, i), 128'(s_p_flag), 128'(v.flag));
            chk($sformatf("%s[%0d] valid", tag, i), 128'(out_valid), 128'(v.ov));
            chk($sformatf("%s[%0d] err", tag, i), 128'(frame_err), 128'(v.err));
            if (v.ov) chk($sformatf("%s[%0d] grp", tag, i), 128'(out_grp), 128'(v.grp));
            chk($sformatf("%s[%0d] re", tag, i), 128'({out0_re, out1_re, out2_re, out3_re}),
                128'({v.ore[0], v.ore[1], v.ore[2], v.ore[3]}));
            chk($sformatf("%s[%0d] im", tag, i), 128'({out0_im, out1_im, out2_im, out3_im}),
                128'({v.oim[0], v.oim[1], v.oim[2], v.oim[3]}));
        end
        vq.delete();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({s_p_flag, out_valid, out_grp, frame_err,
                     out0_re, out0_im, out1_re, out1_im, out2_re, out2_im, out3_re, out3_im});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0; bad = 0; cyc = 0;
        hold_re = '0; hold_im = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", all_outs(), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        build_frame(0, 1'b0, 1'b0, 15);
        run("t1");

        build_frame(0, 1'b1, 1'b0, 15);
        run("t2");

        flag_cyc.delete();
        build_frame(0, 1'b0, 1'b0, 15);
        build_frame(100, 1'b0, 1'b0, 15);
        run("t3");
        chk("t3 flag count", 128'(flag_cyc.size()), 128'd2);
        if (flag_cyc.size() == 2)
            chk("t3 flag spacing", 128'(flag_cyc[1] - flag_cyc[0]), 128'd16);

        build_frame(150, 1'b0, 1'b0, 13);
        add_idle(1'b1);
        build_frame(200, 1'b0, 1'b0, 15);
        run("t4");

        build_frame(50, 1'b0, 1'b0, 14);
        run("t5a");
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5 async reset outputs", all_outs(), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_re = '0; hold_im = '0;
        build_frame(300, 1'b0, 1'b0, 15);
        run("t5b");

        build_frame(0, 1'b0, 1'b1, 15);
        run("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
